// File: rtl/sync_chk_pkg.sv
// -----------------------------------------------------------------------------
// sync_chk_pkg
//
// Shared definitions for the synchronizer sequence checker:
//   - chk_state_e : checker FSM states (IDLE = waiting for a seed word,
//                   TRACK = locked onto the incrementing pattern)
//   - out_sel_e   : encodings of the out_sel pin, selecting which statistic
//                   is driven onto result_out
//   - DEF_N / DEF_CW / RES_W : default data width, default counter width and
//                   the fixed width of the result pins
// -----------------------------------------------------------------------------
package sync_chk_pkg;

    localparam int DEF_N  = 8;   // data word width
    localparam int DEF_CW = 8;   // statistics counter width
    localparam int RES_W  = 8;   // result_out pin width (fixed)

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } chk_state_e;

    typedef enum logic [1:0] {
        SEL_GOOD   = 2'd0,
        SEL_ERR    = 2'd1,
        SEL_GLITCH = 2'd2,
        SEL_LAST   = 2'd3
    } out_sel_e;

endpackage : sync_chk_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//
// Saturating up-counter used for each checker statistic. It counts one per
// enabled cycle with inc high and sticks at all-ones instead of wrapping.
//
// Ports:
//   clk    in   1   clock
//   rst_n  in   1   synchronous active-low reset (count -> 0)
//   ena    in   1   enable; low holds the count
//   clr    in   1   synchronous clear (count -> 0), wins over ena
//   inc    in   1   increment request for this cycle
//   count  out  CW  current count
// -----------------------------------------------------------------------------
module sat_counter
    import sync_chk_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            // clr beats ena so a frozen checker can still be cleared
            count <= '0;
        end else if (ena && inc && (count != CNT_MAX)) begin
            count <= count + CW'(1);
        end
    end

endmodule : sat_counter

// File: rtl/sync_seq_checker.sv
// -----------------------------------------------------------------------------
// sync_seq_checker
//
// Destination-domain checker behind a bus synchronizer. The source sends an
// incrementing counter, one word per strobe. The checker seeds itself from
// the first strobed word, then counts words that follow the pattern
// (good_cnt), words that break it (err_cnt) and bus changes seen without a
// strobe (glitch_cnt). One statistic is presented on result_out.
//
// Strobe semantics: valid_in is a one-cycle pulse qualifying data_in; there
// is no back-pressure. A strobe is consumed on every cycle where rst_n, clr
// and ena allow the checker to advance (ena high, clr low); on any other
// cycle it is dropped. A strobe held high for several cycles is seen as one
// strobe per cycle.
//
// Ports:
//   clk         in   1   destination clock
//   rst_n       in   1   synchronous active-low reset
//   ena         in   1   global enable; low freezes all state
//   data_in     in   N   synchronized data word
//   valid_in    in   1   synchronized strobe
//   clr         in   1   synchronous clear of counters, lock and err_flag
//   out_sel     in   2   0 good_cnt, 1 err_cnt, 2 glitch_cnt, 3 last_word
//   result_out  out  8   selected value, zero-extended / truncated to 8 bits
//   locked      out  1   high while the FSM is in TRACK
//   err_flag    out  1   sticky sequence-error flag
// -----------------------------------------------------------------------------
module sync_seq_checker
    import sync_chk_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int CW = DEF_CW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N-1:0]     data_in,
    input  logic             valid_in,
    input  logic             clr,
    input  logic [1:0]       out_sel,
    output logic [RES_W-1:0] result_out,
    output logic             locked,
    output logic             err_flag
);

    // -------------------------------------------------------------------------
    // Registered state. state is kept as a named enum so checkers can bind to
    // it directly; locked_q mirrors (state == TRACK) as a registered output.
    // -------------------------------------------------------------------------
    chk_state_e      state;
    logic [N-1:0]    last_word;
    logic [N-1:0]    data_q;
    logic            err_flag_q;
    logic            locked_q;

    logic [CW-1:0]   good_cnt;
    logic [CW-1:0]   err_cnt;
    logic [CW-1:0]   glitch_cnt;

    // -------------------------------------------------------------------------
    // Event decode. The ena/clr qualification lives inside the counters, so
    // these only describe what the current cycle would mean if it advances.
    // -------------------------------------------------------------------------
    logic [N-1:0]    next_expected;
    logic            seq_match;
    logic            good_inc;
    logic            err_inc;
    logic            glitch_inc;

    // Modulo-2^N increment: 2^N-1 followed by 0 is a match.
    assign next_expected = last_word + N'(1);
    assign seq_match     = (data_in == next_expected);

    assign good_inc   = (state == TRACK) &&  valid_in &&  seq_match;
    assign err_inc    = (state == TRACK) &&  valid_in && !seq_match;
    // A bus change without a strobe means the crossing was not coherent.
    // Comparing against last cycle's word counts a change-and-hold once and
    // a toggling bus once per cycle.
    assign glitch_inc = (state == TRACK) && !valid_in && (data_in != data_q);

    // -------------------------------------------------------------------------
    // FSM, last_word, data_q and err_flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            locked_q   <= 1'b0;
            last_word  <= '0;
            data_q     <= '0;
            err_flag_q <= 1'b0;
        end else if (clr) begin
            // Any strobe in the clr cycle is discarded. data_q still tracks
            // the bus so the first cycle after clr does not see a false change.
            state      <= IDLE;
            locked_q   <= 1'b0;
            last_word  <= '0;
            data_q     <= data_in;
            err_flag_q <= 1'b0;
        end else if (ena) begin
            data_q <= data_in;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        last_word <= data_in;
                        state     <= TRACK;
                        locked_q  <= 1'b1;
                    end
                end
                TRACK: begin
                    if (valid_in) begin
                        // Always resync to the received word so one bad word
                        // costs a single error rather than a run of them.
                        last_word <= data_in;
                        if (!seq_match) begin
                            err_flag_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Statistics counters
    // -------------------------------------------------------------------------
    sat_counter #(.CW(CW)) u_good_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .clr   (clr),
        .inc   (good_inc),
        .count (good_cnt)
    );

    sat_counter #(.CW(CW)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .clr   (clr),
        .inc   (err_inc),
        .count (err_cnt)
    );

    sat_counter #(.CW(CW)) u_glitch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .clr   (clr),
        .inc   (glitch_inc),
        .count (glitch_cnt)
    );

    // -------------------------------------------------------------------------
    // Fit each statistic to the fixed 8-bit result pins.
    // -------------------------------------------------------------------------
    logic [RES_W-1:0] good_r;
    logic [RES_W-1:0] err_r;
    logic [RES_W-1:0] glitch_r;
    logic [RES_W-1:0] last_r;

    if (CW >= RES_W) begin : g_cnt_trunc
        assign good_r   = good_cnt[RES_W-1:0];
        assign err_r    = err_cnt[RES_W-1:0];
        assign glitch_r = glitch_cnt[RES_W-1:0];
    end else begin : g_cnt_ext
        assign good_r   = {{(RES_W-CW){1'b0}}, good_cnt};
        assign err_r    = {{(RES_W-CW){1'b0}}, err_cnt};
        assign glitch_r = {{(RES_W-CW){1'b0}}, glitch_cnt};
    end

    if (N >= RES_W) begin : g_word_trunc
        assign last_r = last_word[RES_W-1:0];
    end else begin : g_word_ext
        assign last_r = {{(RES_W-N){1'b0}}, last_word};
    end

    // -------------------------------------------------------------------------
    // Output mux: purely combinational so an out_sel change shows up in the
    // same cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        result_out = '0;
        case (out_sel_e'(out_sel))
            SEL_GOOD:   result_out = good_r;
            SEL_ERR:    result_out = err_r;
            SEL_GLITCH: result_out = glitch_r;
            SEL_LAST:   result_out = last_r;
            default:    result_out = '0;
        endcase
    end

    assign locked   = locked_q;
    assign err_flag = err_flag_q;

endmodule : sync_seq_checker

// File: tb/tb_sync_seq_checker.sv
// -----------------------------------------------------------------------------
// tb_sync_seq_checker
//
// Two checker instances share one set of inputs: dut_a with 8-bit counters
// and dut_b with 2-bit counters. A table of vectors drives dut_a, each with
// the hand-derived state expected after its clock edge; those expectations
// go through a queue and are compared once the edge has happened. A
// hand-written sequence then drives dut_b into counter saturation and
// exercises clr together with a strobe.
// -----------------------------------------------------------------------------
module tb_sync_seq_checker;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       clr;
    logic       valid_in;
    logic [7:0] data_in;
    logic [1:0] out_sel;

    logic [7:0] result_a;
    logic       locked_a;
    logic       err_flag_a;
    logic [7:0] result_b;
    logic       locked_b;
    logic       err_flag_b;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    sync_seq_checker #(.N(8), .CW(8)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .clr        (clr),
        .out_sel    (out_sel),
        .result_out (result_a),
        .locked     (locked_a),
        .err_flag   (err_flag_a)
    );

    sync_seq_checker #(.N(8), .CW(2)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .clr        (clr),
        .out_sel    (out_sel),
        .result_out (result_b),
        .locked     (locked_b),
        .err_flag   (err_flag_b)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst_n;
        logic       ena;
        logic       clr;
        logic       valid;
        logic [7:0] data;
        logic [7:0] good;
        logic [7:0] err;
        logic [7:0] glitch;
        logic [7:0] last;
        logic       locked;
        logic       eflag;
    } vec_t;

    vec_t vecs[$];

    // expected word: {good, err, glitch, last, locked, eflag}
    logic [33:0] exp_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic void add_vec(input logic r, input logic e, input logic c,
                                    input logic v, input logic [7:0] d,
                                    input logic [7:0] g, input logic [7:0] er,
                                    input logic [7:0] gl, input logic [7:0] l,
                                    input logic lk, input logic ef);
        vec_t t;
        t.rst_n = r;  t.ena = e;    t.clr = c;     t.valid = v;  t.data = d;
        t.good  = g;  t.err = er;   t.glitch = gl; t.last = l;
        t.locked = lk; t.eflag = ef;
        vecs.push_back(t);
    endfunction

    // ---------------- scoreboard check ----------------
    task automatic check(input string name, input int idx,
                         input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s (step %0d): got 0x%02h, expected 0x%02h", name, idx, got, want);
        end
    endtask

    // ---------------- driver ----------------
    // Drive on the falling edge, let the rising edge sample, then settle 1ns.
    task automatic step(input logic r, input logic e, input logic c,
                        input logic v, input logic [7:0] d);
        @(negedge clk);
        rst_n    = r;
        ena      = e;
        clr      = c;
        valid_in = v;
        data_in  = d;
        @(posedge clk);
        #1;
    endtask

    // Sweep out_sel over all four statistics of one instance.
    task automatic check_stats(input string tag, input int idx, input logic use_b,
                               input logic [7:0] g, input logic [7:0] er,
                               input logic [7:0] gl, input logic [7:0] l);
        out_sel = 2'd0; #1;
        check({tag, ".good"},   idx, use_b ? result_b : result_a, g);
        out_sel = 2'd1; #1;
        check({tag, ".err"},    idx, use_b ? result_b : result_a, er);
        out_sel = 2'd2; #1;
        check({tag, ".glitch"}, idx, use_b ? result_b : result_a, gl);
        out_sel = 2'd3; #1;
        check({tag, ".last"},   idx, use_b ? result_b : result_a, l);
        out_sel = 2'd0;
    endtask

    // ---------------- test ----------------
    initial begin
        logic [33:0] exp_w;

        rst_n = 1'b0; ena = 1'b1; clr = 1'b0; valid_in = 1'b0;
        data_in = 8'h00; out_sel = 2'd0;

        //      rst ena clr  v  data   good  err  glit  last lk ef
        // reset and seed
        add_vec(0, 1, 0, 0, 8'h00, 8'd0, 8'd0, 8'd0, 8'h00, 0, 0);
        add_vec(1, 1, 0, 1, 8'h10, 8'd0, 8'd0, 8'd0, 8'h10, 1, 0);
        add_vec(1, 1, 0, 0, 8'h10, 8'd0, 8'd0, 8'd0, 8'h10, 1, 0);
        // clean sequence with wrap through 0xFF -> 0x00
        add_vec(1, 1, 1, 0, 8'hFD, 8'd0, 8'd0, 8'd0, 8'h00, 0, 0);
        add_vec(1, 1, 0, 1, 8'hFD, 8'd0, 8'd0, 8'd0, 8'hFD, 1, 0);
        add_vec(1, 1, 0, 1, 8'hFE, 8'd1, 8'd0, 8'd0, 8'hFE, 1, 0);
        add_vec(1, 1, 0, 1, 8'hFF, 8'd2, 8'd0, 8'd0, 8'hFF, 1, 0);
        add_vec(1, 1, 0, 1, 8'h00, 8'd3, 8'd0, 8'd0, 8'h00, 1, 0);
        add_vec(1, 1, 0, 1, 8'h01, 8'd4, 8'd0, 8'd0, 8'h01, 1, 0);
        // sequence error and resync
        add_vec(1, 1, 1, 0, 8'h20, 8'd0, 8'd0, 8'd0, 8'h00, 0, 0);
        add_vec(1, 1, 0, 1, 8'h20, 8'd0, 8'd0, 8'd0, 8'h20, 1, 0);
        add_vec(1, 1, 0, 1, 8'h21, 8'd1, 8'd0, 8'd0, 8'h21, 1, 0);
        add_vec(1, 1, 0, 1, 8'h25, 8'd1, 8'd1, 8'd0, 8'h25, 1, 1);
        add_vec(1, 1, 0, 1, 8'h26, 8'd2, 8'd1, 8'd0, 8'h26, 1, 1);
        // glitches: change, change back, hold, then a legal strobe
        add_vec(1, 1, 1, 0, 8'h30, 8'd0, 8'd0, 8'd0, 8'h00, 0, 0);
        add_vec(1, 1, 0, 1, 8'h30, 8'd0, 8'd0, 8'd0, 8'h30, 1, 0);
        add_vec(1, 1, 0, 0, 8'h31, 8'd0, 8'd0, 8'd1, 8'h30, 1, 0);
        add_vec(1, 1, 0, 0, 8'h30, 8'd0, 8'd0, 8'd2, 8'h30, 1, 0);
        add_vec(1, 1, 0, 0, 8'h30, 8'd0, 8'd0, 8'd2, 8'h30, 1, 0);
        add_vec(1, 1, 0, 1, 8'h31, 8'd1, 8'd0, 8'd2, 8'h31, 1, 0);
        // ena low: three strobes lost, bus changes not counted
        add_vec(1, 0, 0, 1, 8'h32, 8'd1, 8'd0, 8'd2, 8'h31, 1, 0);
        add_vec(1, 0, 0, 1, 8'h33, 8'd1, 8'd0, 8'd2, 8'h31, 1, 0);
        add_vec(1, 0, 0, 1, 8'h34, 8'd1, 8'd0, 8'd2, 8'h31, 1, 0);
        add_vec(1, 1, 0, 0, 8'h31, 8'd1, 8'd0, 8'd2, 8'h31, 1, 0);
        add_vec(1, 1, 0, 1, 8'h32, 8'd2, 8'd0, 8'd2, 8'h32, 1, 0);
        // one-cycle reset while tracking
        add_vec(0, 1, 0, 0, 8'h00, 8'd0, 8'd0, 8'd0, 8'h00, 0, 0);
        add_vec(1, 1, 0, 0, 8'h00, 8'd0, 8'd0, 8'd0, 8'h00, 0, 0);
        // clr wins over ena low and drops a same-cycle strobe
        add_vec(1, 1, 0, 1, 8'h40, 8'd0, 8'd0, 8'd0, 8'h40, 1, 0);
        add_vec(1, 1, 0, 1, 8'h45, 8'd0, 8'd1, 8'd0, 8'h45, 1, 1);
        add_vec(1, 0, 1, 1, 8'h46, 8'd0, 8'd0, 8'd0, 8'h00, 0, 0);
        add_vec(1, 1, 0, 0, 8'h46, 8'd0, 8'd0, 8'd0, 8'h00, 0, 0);
        // bus change in IDLE is not a glitch
        add_vec(1, 1, 0, 0, 8'h47, 8'd0, 8'd0, 8'd0, 8'h00, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            exp_q.push_back({vecs[i].good, vecs[i].err, vecs[i].glitch,
                             vecs[i].last, vecs[i].locked, vecs[i].eflag});
            step(vecs[i].rst_n, vecs[i].ena, vecs[i].clr, vecs[i].valid, vecs[i].data);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL scoreboard (step %0d): got empty queue, expected an entry", i);
            end else begin
                exp_w = exp_q.pop_front();
                check_stats("tbl", i, 1'b0, exp_w[33:26], exp_w[25:18],
                            exp_w[17:10], exp_w[9:2]);
                check("tbl.locked", i, {7'd0, locked_a},   {7'd0, exp_w[1]});
                check("tbl.eflag",  i, {7'd0, err_flag_a}, {7'd0, exp_w[0]});
            end
        end

        // ---- saturation on the 2-bit instance, then clr with a strobe ----
        step(0, 1, 0, 0, 8'h00);
        check_stats("sat.reset", 100, 1'b1, 8'd0, 8'd0, 8'd0, 8'h00);
        step(1, 1, 0, 1, 8'h00);             // seed
        step(1, 1, 0, 1, 8'h05);             // five sequence errors
        step(1, 1, 0, 1, 8'h0A);
        step(1, 1, 0, 1, 8'h10);
        step(1, 1, 0, 1, 8'h20);
        step(1, 1, 0, 1, 8'h30);
        check_stats("sat.b", 101, 1'b1, 8'd0, 8'd3, 8'd0, 8'h30);
        check_stats("sat.a", 101, 1'b0, 8'd0, 8'd5, 8'd0, 8'h30);
        check("sat.b.locked", 101, {7'd0, locked_b},   8'd1);
        check("sat.b.eflag",  101, {7'd0, err_flag_b}, 8'd1);

        step(1, 1, 1, 1, 8'h31);             // clr with a strobe that would match
        check_stats("clr.b", 102, 1'b1, 8'd0, 8'd0, 8'd0, 8'h00);
        check_stats("clr.a", 102, 1'b0, 8'd0, 8'd0, 8'd0, 8'h00);
        check("clr.b.locked", 102, {7'd0, locked_b},   8'd0);
        check("clr.b.eflag",  102, {7'd0, err_flag_b}, 8'd0);

        step(1, 1, 0, 0, 8'h31);
        check("clr.after.locked", 103, {7'd0, locked_b}, 8'd0);
        step(1, 1, 0, 1, 8'h31);             // first strobe after clr seeds again
        check_stats("reseed.b", 104, 1'b1, 8'd0, 8'd0, 8'd0, 8'h31);
        check("reseed.b.locked", 104, {7'd0, locked_b}, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_sync_seq_checker
